// File: rtl/timer_scheduler_pkg.sv
// Shared constants, arbiter state encoding and round-robin helper for the
// periodic event scheduler.
package timer_scheduler_pkg;

    localparam int NUM_CH       = 4;
    localparam int CH_W         = 2;
    localparam int DEF_PRESCALE = 1000;
    localparam int DEF_PER_W    = 10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Scanning downward and overwriting makes the closest set bit above 'last' win.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] idx;
        rr_pick = last;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = last + CH_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Configuration write port and valid/ready event port of the scheduler.
interface timer_scheduler_if #(
    parameter int PER_W = 10
) ();
    import timer_scheduler_pkg::*;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [PER_W-1:0] cfg_period;
    logic             evt_valid;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_ready;

    modport master (
        output cfg_we, cfg_ch, cfg_period, evt_ready,
        input  evt_valid, evt_ch
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, evt_ready,
        output evt_valid, evt_ch
    );

endinterface

// File: rtl/timer_scheduler_tick_gen.sv
// Prescaler producing the shared one-cycle base tick; the count freezes
// while enable is low.
module tick_gen
    import timer_scheduler_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk_in,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int              PC_W    = $clog2(PRESCALE);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] pcnt_q, pcnt_d;
    logic            wrap;

    assign wrap = (pcnt_q == PC_LAST);
    assign tick = enable && wrap;

    always_comb begin
        pcnt_d = pcnt_q;
        if (enable) begin
            pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Four-channel periodic scheduler: per-channel tick down-counters feed a
// round-robin arbiter that serializes expirations onto one event port.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int PER_W    = DEF_PER_W
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                enable,
    input  logic                ovr_clr,
    output logic                tick,
    output logic [NUM_CH-1:0]   active,
    output logic [NUM_CH-1:0]   overrun,
    timer_scheduler_if.slave    bus
);

    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [PER_W-1:0]  period_q [NUM_CH];
    logic [PER_W-1:0]  period_d [NUM_CH];
    logic [PER_W-1:0]  ccnt_q   [NUM_CH];
    logic [PER_W-1:0]  ccnt_d   [NUM_CH];

    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] disarm;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant_vec;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CH_W-1:0]   pick;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // A config write to a channel suppresses its expiry in the same cycle.
    always_comb begin
        wr_hit = '0;
        disarm = '0;
        expire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
            disarm[i] = wr_hit[i] && (bus.cfg_period == '0);
            expire[i] = tick && armed_q[i] && (ccnt_q[i] == PER_W'(1)) && !wr_hit[i];
        end
    end

    always_comb begin
        armed_d   = armed_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = period_q[i];
            ccnt_d[i]   = ccnt_q[i];

            if (wr_hit[i]) begin
                if (disarm[i]) begin
                    armed_d[i] = 1'b0;
                end else begin
                    armed_d[i]  = 1'b1;
                    period_d[i] = bus.cfg_period;
                    ccnt_d[i]   = bus.cfg_period;
                end
            end else if (tick && armed_q[i]) begin
                ccnt_d[i] = expire[i] ? period_q[i] : ccnt_q[i] - 1'b1;
            end

            // An expiry coinciding with its own grant re-arms pending without overrun.
            if (disarm[i]) begin
                pending_d[i] = 1'b0;
            end else if (expire[i]) begin
                pending_d[i] = 1'b1;
            end else if (grant_vec[i]) begin
                pending_d[i] = 1'b0;
            end

            if (expire[i] && pending_q[i] && !grant_vec[i]) begin
                overrun_d[i] = 1'b1;
            end else if (ovr_clr) begin
                overrun_d[i] = 1'b0;
            end
        end
    end

    assign req  = pending_q & ~disarm;
    assign pick = rr_pick(req, last_q);

    // Grants happen from IDLE or on a handshake, allowing one event per cycle.
    always_comb begin
        state_d   = state_q;
        evt_ch_d  = evt_ch_q;
        last_d    = last_q;
        grant_vec = '0;
        if ((state_q == ARB_IDLE) || bus.evt_ready) begin
            if (|req) begin
                grant_vec[pick] = 1'b1;
                evt_ch_d        = pick;
                last_d          = pick;
                state_d         = ARB_HOLD;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            armed_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                ccnt_q[i]   <= '0;
            end
            state_q  <= ARB_IDLE;
            evt_ch_q <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
        end else begin
            armed_q   <= armed_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                ccnt_q[i]   <= ccnt_d[i];
            end
            state_q  <= state_d;
            evt_ch_q <= evt_ch_d;
            last_q   <= last_d;
        end
    end

    assign bus.evt_valid = (state_q == ARB_HOLD);
    assign bus.evt_ch    = evt_ch_q;
    assign active        = armed_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with PRESCALE=4; all activity is
// aligned to falling edges, with cycle index 0 at reset release.
module tb_timer_scheduler;
    import timer_scheduler_pkg::*;

    localparam int PRESCALE = 4;
    localparam int PER_W    = 10;

    logic              clk_in  = 1'b0;
    logic              rst     = 1'b1;
    logic              enable  = 1'b0;
    logic              ovr_clr = 1'b0;
    logic              tick;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] overrun;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    timer_scheduler_if #(.PER_W(PER_W)) bus ();

    timer_scheduler #(
        .PRESCALE (PRESCALE),
        .PER_W    (PER_W)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .enable  (enable),
        .ovr_clr (ovr_clr),
        .tick    (tick),
        .active  (active),
        .overrun (overrun),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic runUntil(input int target);
        while (cyc < target) nextCycle();
    endtask

    task automatic applyStimulus(input int ch, input int per);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = CH_W'(ch);
        bus.cfg_period = PER_W'(per);
        nextCycle();
        bus.cfg_we     = 1'b0;
        bus.cfg_period = '0;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        enable        = 1'b0;
        ovr_clr       = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_period = '0;
        bus.evt_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        rst    = 1'b0;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        int seq [4] = '{0, 2, 3, 0};
        int seen;
        logic expV;

        // Reset values and tick phase
        doReset();
        checkOutput("rst_valid", bus.evt_valid, 0);
        checkOutput("rst_ch", bus.evt_ch, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_overrun", overrun, 0);
        for (int i = 0; i < 12; i++) begin
            checkOutput("tick_phase", tick, (i % 4 == 3) ? 1 : 0);
            nextCycle();
        end

        // Single channel, period 3, sink always ready
        doReset();
        bus.evt_ready = 1'b1;
        applyStimulus(1, 3);
        for (int i = 1; i <= 40; i++) begin
            expV = (i == 13 || i == 25 || i == 37);
            checkOutput("p3_valid", bus.evt_valid, expV);
            if (expV) checkOutput("p3_ch", bus.evt_ch, 1);
            nextCycle();
        end

        // Backpressure, overrun, round-robin back-to-back drain
        doReset();
        applyStimulus(0, 1);
        applyStimulus(2, 1);
        applyStimulus(3, 1);
        runUntil(5);
        checkOutput("bp_first_valid", bus.evt_valid, 1);
        checkOutput("bp_first_ch", bus.evt_ch, 0);
        runUntil(23);
        checkOutput("bp_hold_valid", bus.evt_valid, 1);
        checkOutput("bp_hold_ch", bus.evt_ch, 0);
        checkOutput("bp_overrun", overrun, 4'b1101);
        for (int k = 0; k < 4; k++) begin
            checkOutput("b2b_valid", bus.evt_valid, 1);
            checkOutput("b2b_ch", bus.evt_ch, seq[k]);
            bus.evt_ready = 1'b1;
            nextCycle();
        end
        applyStimulus(0, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 0);
        checkOutput("disarm_active", active, 0);
        ovr_clr = 1'b1;
        nextCycle();
        ovr_clr = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);
        repeat (4) nextCycle();
        checkOutput("drained_valid", bus.evt_valid, 0);

        // Disarm a pending channel while another event is presented
        doReset();
        applyStimulus(0, 2);
        applyStimulus(2, 2);
        runUntil(9);
        checkOutput("dis_valid", bus.evt_valid, 1);
        checkOutput("dis_ch", bus.evt_ch, 0);
        applyStimulus(2, 0);
        checkOutput("dis_active2", active, 4'b0001);
        checkOutput("dis_keep_ch", bus.evt_ch, 0);
        applyStimulus(0, 0);
        checkOutput("dis_active_all", active, 0);
        checkOutput("dis_keep_valid", bus.evt_valid, 1);
        bus.evt_ready = 1'b1;
        nextCycle();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.evt_valid) seen++;
            nextCycle();
        end
        checkOutput("dis_no_ch2", seen, 0);

        // Config write colliding with an expiring tick
        doReset();
        bus.evt_ready = 1'b1;
        applyStimulus(1, 2);
        runUntil(7);
        checkOutput("coll_tick", tick, 1);
        applyStimulus(1, 5);
        for (int i = 8; i <= 35; i++) begin
            expV = (i == 29);
            checkOutput("coll_valid", bus.evt_valid, expV);
            if (expV) checkOutput("coll_ch", bus.evt_ch, 1);
            nextCycle();
        end

        // Reset asserted mid-HOLD
        doReset();
        applyStimulus(0, 1);
        runUntil(5);
        checkOutput("pre_rst_valid", bus.evt_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_drop_valid", bus.evt_valid, 0);
        doReset();
        bus.evt_ready = 1'b1;
        checkOutput("post_rst_ch", bus.evt_ch, 0);
        checkOutput("post_rst_active", active, 0);
        checkOutput("post_rst_overrun", overrun, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) checkOutput("post_rst_tick", tick, 1);
            if (bus.evt_valid) seen++;
            nextCycle();
        end
        checkOutput("post_rst_no_evt", seen, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Multi-channel periodic event scheduler built on a single shared timebase. A prescaler divides `clk_in` into a one-cycle base tick (1 kHz at 1 MHz with defaults). Up to four software-configured channels count base ticks and expire at their own periods. Expirations are serialized onto one valid/ready event port by a round-robin arbiter, so downstream logic (display scan, debounce, LED blink) shares one timebase and one event sink.

## Interface

Parameters:
- `NUM_CH`, default 4: number of channels; fixed at 4 in this revision, so `cfg_ch` and `evt_ch` are 2 bits.
- `PRESCALE`, default 1000: `clk_in` cycles per base tick; minimum 2.
- `PER_W`, default 10: channel period width in base ticks.

Ports:
- `clk_in`, input, 1: system clock; all state on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: prescaler runs while high; holds its count while low.
- `cfg_we`, input, 1: one-cycle config write strobe.
- `cfg_ch`, input, 2: channel index for the write.
- `cfg_period`, input, `PER_W`: new period in ticks; 0 disarms the channel.
- `tick`, output, 1: one-cycle base-tick pulse.
- `active`, output, `NUM_CH`: per-channel armed flag.
- `evt_valid`, output, 1: event available.
- `evt_ch`, output, 2: channel of the presented event.
- `evt_ready`, input, 1: sink accepts the event.
- `overrun`, output, `NUM_CH`: sticky per-channel overrun flag.
- `ovr_clr`, input, 1: clears all `overrun` bits.

## Operation

Prescaler:
- `pcnt` counts 0..`PRESCALE`-1 while `enable` is high, then wraps to 0.
- `tick` is 1 during the cycle in which `pcnt` == `PRESCALE`-1 and `enable` is high.

Channel i:
- Each channel has an armed flag, a `period` register and a down counter `ccnt`, all `PER_W` wide.
- `cfg_we` with nonzero `cfg_period`: `period` and `ccnt` are loaded, the armed flag is set, and `pending[i]` is left unchanged.
- `cfg_we` with `cfg_period` == 0: the channel is disarmed and `pending[i]` is cleared. An event already presented on `evt_*` is unaffected.
- On `tick` with the channel armed:
  - If `ccnt` == 1, the channel expires: `ccnt` reloads from `period` and `pending[i]` is set.
  - Otherwise `ccnt` decrements.
- First expiry falls on the p-th tick after a write of period p, then every p ticks.
- Overrun: an expiry while `pending[i]` is already set sets `overrun[i]`; the pending event is not duplicated.
- A config write and a tick on the same channel in the same cycle: the write wins and no expiry occurs that cycle.
- `ovr_clr` and a new overrun in the same cycle: the set wins.

Arbiter, two states:
- IDLE: `evt_valid` = 0. If any `pending` bit is set, grant the first set bit searching upward (mod 4) from `last`+1. Register `evt_ch`, clear that `pending` bit, set `last`, and go to HOLD.
- HOLD: `evt_valid` = 1 and `evt_ch` is stable until `evt_ready`.
  - On handshake with other pending bits set, grant the next channel in the same cycle and stay in HOLD (back-to-back events).
  - On handshake with nothing pending, go to IDLE.
- A pending-clear by grant and a new expiry of the same channel in the same cycle: the bit stays set and no overrun is raised.

Reset values:
- `pcnt`, all `ccnt`, `period`, armed and `pending` bits: 0.
- `tick`, `active`, `evt_valid`, `overrun`: 0. `evt_ch`: 0.
- `last` = 3, so channel 0 has first priority.
- Arbiter state: IDLE.
- Reset mid-HOLD drops `evt_valid` immediately and discards the event.

## Timing

- First `tick`: cycle `PRESCALE` after `rst` deasserts with `enable` high (cycle index `PRESCALE`-1, counting from 0).
- Expiry edge: `pending[i]` is visible the cycle after the `tick` cycle (T+1).
- `evt_valid` rises at T+2 when the arbiter is IDLE.
- Handshake is complete on any edge with `evt_valid` && `evt_ready`.
- `evt_valid` never drops, and `evt_ch` never changes, without a handshake (except on reset).
- Sustained throughput: one event per cycle.
- `active` reflects a config write the cycle after `cfg_we`.

## Structure

- Shared header/package holds: `NUM_CH`, channel index width (2), arbiter state encodings (IDLE = 0, HOLD = 1), and default `PRESCALE`/`PER_W`.
- Natural sub-module: `tick_gen`, containing the prescaler, `enable` and `tick`.
- Channel counters and the arbiter stay in `timer_scheduler`.
- Target size: roughly 200 RTL lines.

## Test plan

All scenarios run with `PRESCALE`=4.

- Reset, then `enable`=1 -> `tick` pulses at cycles 3, 7, 11; `evt_valid`=0, `active`=0000.
- Write ch1 period 3, `evt_ready` held 1 -> `evt_valid` with `evt_ch`=1 appears 2 cycles after the 3rd tick following the write, then again every 12 cycles.
- Ch0, ch2 and ch3 all period 1, `evt_ready`=0 for 20 cycles, then 1 -> the first event is `evt_ch`=0 and stays stable. After release the order is 0, 2, 3, 0, … back-to-back with no idle cycles. `overrun` = 1101, and it clears on `ovr_clr`.
- Write ch2 period 0 while `pending[2]`=1 and ch0 is presented -> ch0 event completes, ch2 event never issues, `active[2]`=0.
- Config write to ch1 (period 5) in a tick cycle where ch1 `ccnt`==1 -> no event that tick; the next ch1 event comes 5 ticks later.
- Assert `rst` while `evt_valid`=1 -> `evt_valid`=0 that cycle. After release, all registers are back to their reset values and no stale event appears.
